// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster sequencer producing h/v counters, dv/hs/vs strobes,
// LAT-delayed strobe copies and frame bookkeeping. Streaming starts and stops
// only on frame boundaries.
module video_timing_ctrl #(
   parameter int unsigned HRES   = 1600,
   parameter int unsigned HFP    = 24,
   parameter int unsigned HSW    = 80,
   parameter int unsigned HBP    = 96,
   parameter int unsigned VRES   = 900,
   parameter int unsigned VFP    = 1,
   parameter int unsigned VSW    = 3,
   parameter int unsigned VBP    = 96,
   parameter bit          HS_POL = 1'b1,
   parameter bit          VS_POL = 1'b1,
   parameter int unsigned LAT    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   output logic [10:0] h_cnt,
   output logic [10:0] v_cnt,
   output logic        dv_o,
   output logic        hs_o,
   output logic        vs_o,
   output logic        dv_d,
   output logic        hs_d,
   output logic        vs_d,
   output logic        frame_start,
   output logic [15:0] frame_cnt,
   output logic        busy
);

   localparam int unsigned CW   = 11;
   localparam int unsigned DW   = CW + 1;
   localparam int unsigned FW   = 16;
   localparam int unsigned HTOT = HRES + HFP + HSW + HBP;
   localparam int unsigned VTOT = VRES + VFP + VSW + VBP;

   // Decode thresholds carry one extra bit so a sync ending at 2048 still fits.
   localparam logic [CW-1:0] C_HLAST  = CW'(HTOT - 1);
   localparam logic [CW-1:0] C_VLAST  = CW'(VTOT - 1);
   localparam logic [DW-1:0] C_HRES   = DW'(HRES);
   localparam logic [DW-1:0] C_VRES   = DW'(VRES);
   localparam logic [DW-1:0] C_HS_ON  = DW'(HRES + HFP);
   localparam logic [DW-1:0] C_HS_OFF = DW'(HRES + HFP + HSW);
   localparam logic [DW-1:0] C_VS_ON  = DW'(VRES + VFP);
   localparam logic [DW-1:0] C_VS_OFF = DW'(VRES + VFP + VSW);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_h;
   logic [CW-1:0] r_v;
   logic          r_dv;
   logic          r_hs;
   logic          r_vs;
   logic          r_fs;
   logic [FW-1:0] r_fcnt;
   logic          r_busy;
   logic [2:0]    r_dly [LAT];

   logic          w_h_last;
   logic          w_v_last;
   logic          w_frame_end;
   logic [CW-1:0] w_h_adv;
   logic [CW-1:0] w_v_adv;

   function automatic logic f_dv(input logic [CW-1:0] h, input logic [CW-1:0] v);
      return ({1'b0, h} < C_HRES) && ({1'b0, v} < C_VRES);
   endfunction

   function automatic logic f_hs(input logic [CW-1:0] h);
      return (({1'b0, h} >= C_HS_ON) && ({1'b0, h} < C_HS_OFF)) ? HS_POL : !HS_POL;
   endfunction

   function automatic logic f_vs(input logic [CW-1:0] v);
      return (({1'b0, v} >= C_VS_ON) && ({1'b0, v} < C_VS_OFF)) ? VS_POL : !VS_POL;
   endfunction

   // Raster advance: next counter position and last-clock-of-frame detect.
   assign w_h_last    = (r_h == C_HLAST);
   assign w_v_last    = (r_v == C_VLAST);
   assign w_frame_end = w_h_last && w_v_last;
   assign w_h_adv     = w_h_last ? '0 : r_h + CW'(1);
   assign w_v_adv     = w_h_last ? (w_v_last ? '0 : r_v + CW'(1)) : r_v;

   // Sequencer FSM with counters and strobes registered alongside the state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_h     <= '0;
         r_v     <= '0;
         r_dv    <= 1'b0;
         r_hs    <= !HS_POL;
         r_vs    <= !VS_POL;
         r_fs    <= 1'b0;
         r_fcnt  <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_fs <= 1'b0;
               if (start) begin
                  r_state <= S_RUN;
                  r_h     <= '0;
                  r_v     <= '0;
                  r_dv    <= f_dv('0, '0);
                  r_hs    <= f_hs('0);
                  r_vs    <= f_vs('0);
                  r_fs    <= 1'b1;
                  r_fcnt  <= r_fcnt + FW'(1);
                  r_busy  <= 1'b1;
               end
            end
            S_RUN, S_DRAIN: begin
               if ((r_state == S_DRAIN) && !start && w_frame_end) begin
                  r_state <= S_IDLE;
                  r_h     <= '0;
                  r_v     <= '0;
                  r_dv    <= 1'b0;
                  r_hs    <= !HS_POL;
                  r_vs    <= !VS_POL;
                  r_fs    <= 1'b0;
                  r_busy  <= 1'b0;
               end else begin
                  if (r_state == S_RUN) begin
                     r_state <= stop ? S_DRAIN : S_RUN;
                  end else begin
                     r_state <= start ? S_RUN : S_DRAIN;
                  end
                  r_h  <= w_h_adv;
                  r_v  <= w_v_adv;
                  r_dv <= f_dv(w_h_adv, w_v_adv);
                  r_hs <= f_hs(w_h_adv);
                  r_vs <= f_vs(w_v_adv);
                  r_fs <= w_frame_end;
                  if (w_frame_end) begin
                     r_fcnt <= r_fcnt + FW'(1);
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Strobe delay line; free-running so it flushes naturally once idle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(LAT); i++) begin
            r_dly[i] <= {1'b0, !HS_POL, !VS_POL};
         end
      end else begin
         r_dly[0] <= {r_dv, r_hs, r_vs};
         for (int i = 1; i < int'(LAT); i++) begin
            r_dly[i] <= r_dly[i-1];
         end
      end
   end

   assign h_cnt       = r_h;
   assign v_cnt       = r_v;
   assign dv_o        = r_dv;
   assign hs_o        = r_hs;
   assign vs_o        = r_vs;
   assign dv_d        = r_dly[LAT-1][2];
   assign hs_d        = r_dly[LAT-1][1];
   assign vs_d        = r_dly[LAT-1][0];
   assign frame_start = r_fs;
   assign frame_cnt   = r_fcnt;
   assign busy        = r_busy;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl using small raster parameters and a frame-position
// reference model.
module tb_video_timing_ctrl;

   localparam int unsigned HRES = 8, HFP = 2, HSW = 2, HBP = 2;
   localparam int unsigned VRES = 4, VFP = 1, VSW = 1, VBP = 1;
   localparam int unsigned LAT  = 3;
   localparam int unsigned HTOT = HRES + HFP + HSW + HBP;
   localparam int unsigned VTOT = VRES + VFP + VSW + VBP;
   localparam int unsigned FT   = HTOT * VTOT;
   localparam bit          HSP  = 1'b1;
   localparam bit          VSP  = 1'b1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [10:0] h_cnt, v_cnt;
   logic        dv_o, hs_o, vs_o, dv_d, hs_d, vs_d, frame_start, busy;
   logic [15:0] frame_cnt;

   int errors = 0;
   int checks = 0;

   video_timing_ctrl #(
      .HRES(HRES), .HFP(HFP), .HSW(HSW), .HBP(HBP),
      .VRES(VRES), .VFP(VFP), .VSW(VSW), .VBP(VBP),
      .HS_POL(HSP), .VS_POL(VSP), .LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
      .dv_d(dv_d), .hs_d(hs_d), .vs_d(vs_d), .frame_start(frame_start),
      .frame_cnt(frame_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: streaming flag, position within frame, pending stop.
   bit          m_active = 1'b0;
   bit          m_pend = 1'b0;
   int unsigned m_pos = 0;
   logic [10:0] e_h = '0, e_v = '0;
   logic        e_dv = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_fs = 1'b0;
   logic [15:0] e_fcnt = '0;
   logic [2:0]  hist [LAT];

   always @(posedge clk) begin
      bit adv;
      int unsigned hh, vv;
      if (!rst) begin
         for (int i = 0; i < int'(LAT); i++) hist[i] = {1'b0, !HSP, !VSP};
      end else begin
         for (int i = int'(LAT) - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = {e_dv, e_hs, e_vs};
      end
      if (!rst) begin
         m_active = 1'b0; m_pend = 1'b0; m_pos = 0; e_fs = 1'b0; e_fcnt = '0;
      end else if (!m_active) begin
         e_fs = 1'b0;
         if (start) begin
            m_active = 1'b1; m_pend = 1'b0; m_pos = 0; e_fs = 1'b1;
            e_fcnt = e_fcnt + 16'd1;
         end
      end else begin
         adv = 1'b1;
         if (!m_pend) begin
            if (stop) m_pend = 1'b1;
         end else if (start) begin
            m_pend = 1'b0;
         end else if (m_pos == FT - 1) begin
            m_active = 1'b0; m_pos = 0; adv = 1'b0; e_fs = 1'b0;
         end
         if (adv) begin
            m_pos = (m_pos + 1) % FT;
            e_fs  = (m_pos == 0);
            if (e_fs) e_fcnt = e_fcnt + 16'd1;
         end
      end
      hh   = m_active ? m_pos % HTOT : 0;
      vv   = m_active ? m_pos / HTOT : 0;
      e_h  = 11'(hh);
      e_v  = 11'(vv);
      e_dv = m_active && (hh < HRES) && (vv < VRES);
      e_hs = (m_active && hh >= HRES + HFP && hh < HRES + HFP + HSW) ? HSP : !HSP;
      e_vs = (m_active && vv >= VRES + VFP && vv < VRES + VFP + VSW) ? VSP : !VSP;
   end

   logic [45:0] w_obs, w_exp;
   assign w_obs = {h_cnt, v_cnt, dv_o, hs_o, vs_o, dv_d, hs_d, vs_d, frame_start, frame_cnt, busy};
   assign w_exp = {e_h, e_v, e_dv, e_hs, e_vs, hist[LAT-1], e_fs, e_fcnt, m_active};

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b1; stop = 1'b1;
      tick(); tick();
      checks++;
      if (w_obs !== 46'd0) begin
         errors++; $display("FAIL reset_values: got %h want %h", w_obs, 46'd0);
      end
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (w_obs !== w_exp || busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle cyc %0d: got %h want %h", k, w_obs, w_exp);
         end
      end
   endtask

   task automatic test_frame();
      int n_dv = 0, n_hs = 0, n_vs = 0, fs0 = -1, fs1 = -1;
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if ({h_cnt, v_cnt, dv_o, frame_start, frame_cnt} !== {11'd0, 11'd0, 1'b1, 1'b1, 16'd1}) begin
         errors++;
         $display("FAIL first_cycle: got h=%0d v=%0d dv=%b fs=%b fc=%0d want 0 0 1 1 1",
                  h_cnt, v_cnt, dv_o, frame_start, frame_cnt);
      end
      for (int c = 0; c < int'(2 * FT); c++) begin
         checks++;
         if (w_obs !== w_exp) begin
            errors++; $display("FAIL frame_seq cyc %0d: got %h want %h", c, w_obs, w_exp);
         end
         if (dv_o) n_dv++;
         if (hs_o) n_hs++;
         if (vs_o) n_vs++;
         if (frame_start) begin
            if (fs0 < 0) fs0 = c; else if (fs1 < 0) fs1 = c;
         end
         tick();
      end
      checks++;
      if (n_dv != int'(2 * HRES * VRES)) begin
         errors++; $display("FAIL dv_count: got %0d want %0d", n_dv, 2 * HRES * VRES);
      end
      checks++;
      if (n_hs != int'(2 * VTOT * HSW)) begin
         errors++; $display("FAIL hs_count: got %0d want %0d", n_hs, 2 * VTOT * HSW);
      end
      checks++;
      if (n_vs != int'(2 * VSW * HTOT)) begin
         errors++; $display("FAIL vs_count: got %0d want %0d", n_vs, 2 * VSW * HTOT);
      end
      checks++;
      if (fs0 != 0 || fs1 - fs0 != int'(FT)) begin
         errors++; $display("FAIL fs_interval: got %0d->%0d want 0->%0d", fs0, fs1, FT);
      end
   endtask

   task automatic test_stop();
      int n_dv = 0, k = 0;
      while (!(e_h == 11'd3 && e_v == 11'd1) && k < int'(3 * FT)) begin
         checks++;
         if (w_obs !== w_exp) begin
            errors++; $display("FAIL stop_wait cyc %0d: got %h want %h", k, w_obs, w_exp);
         end
         if (frame_start) n_dv = 0;
         if (dv_o) n_dv++;
         tick(); k++;
      end
      stop = 1'b1;
      k = 0;
      while (m_active && k < int'(3 * FT)) begin
         checks++;
         if (w_obs !== w_exp) begin
            errors++; $display("FAIL stop_drain cyc %0d: got %h want %h", k, w_obs, w_exp);
         end
         if (dv_o) n_dv++;
         tick();
         if (k == 0) stop = 1'b0;
         k++;
      end
      checks++;
      if (busy !== 1'b0 || h_cnt !== 11'd0 || dv_o !== 1'b0 || k >= int'(3 * FT)) begin
         errors++; $display("FAIL stop_idle: got busy=%b h=%0d dv=%b cycles=%0d want 0 0 0", busy, h_cnt, dv_o, k);
      end
      checks++;
      if (n_dv != int'(HRES * VRES)) begin
         errors++; $display("FAIL stop_dv_count: got %0d want %0d", n_dv, HRES * VRES);
      end
      for (int j = 0; j < int'(LAT); j++) tick();
      checks++;
      if (dv_d !== 1'b0 || w_obs !== w_exp) begin
         errors++; $display("FAIL dvd_flush: got dv_d=%b vec %h want 0 vec %h", dv_d, w_obs, w_exp);
      end
   endtask

   task automatic test_drain_restart();
      logic [15:0] f0;
      int k = 0;
      start = 1'b1; tick(); start = 1'b0;
      f0 = e_fcnt;
      while (!(e_h == 11'd0 && e_v == 11'd2) && k < int'(3 * FT)) begin tick(); k++; end
      stop = 1'b1; tick(); stop = 1'b0;
      k = 0;
      while (!(e_h == 11'd5 && e_v == 11'd6) && k < int'(3 * FT)) begin
         checks++;
         if (w_obs !== w_exp) begin
            errors++; $display("FAIL drain_wait cyc %0d: got %h want %h", k, w_obs, w_exp);
         end
         tick(); k++;
      end
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < int'(FT); c++) begin
         checks++;
         if (w_obs !== w_exp || busy !== 1'b1) begin
            errors++; $display("FAIL drain_restart cyc %0d: got %h want %h", c, w_obs, w_exp);
         end
         if (frame_start) begin
            checks++;
            if (frame_cnt !== f0 + 16'd1) begin
               errors++; $display("FAIL restart_fcnt: got %0d want %0d", frame_cnt, f0 + 16'd1);
            end
         end
         tick();
      end
   endtask

   task automatic test_start_at_last();
      int k = 0;
      stop = 1'b1; tick(); stop = 1'b0;
      while (!(e_h == 11'(HTOT - 1) && e_v == 11'(VTOT - 1)) && k < int'(3 * FT)) begin tick(); k++; end
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if ({busy, h_cnt, v_cnt, frame_start} !== {1'b1, 11'd0, 11'd0, 1'b1} || w_obs !== w_exp) begin
         errors++; $display("FAIL start_at_last: got busy=%b h=%0d v=%0d fs=%b want 1 0 0 1", busy, h_cnt, v_cnt, frame_start);
      end
   endtask

   task automatic test_idle_start_stop();
      int k = 0;
      stop = 1'b1; tick(); stop = 1'b0;
      while (m_active && k < int'(3 * FT)) begin tick(); k++; end
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      for (int c = 0; c < int'(FT); c++) tick();
      checks++;
      if ({busy, frame_start, h_cnt, v_cnt} !== {1'b1, 1'b1, 11'd0, 11'd0} || w_obs !== w_exp) begin
         errors++; $display("FAIL idle_stop_ignored: got busy=%b fs=%b h=%0d v=%0d want 1 1 0 0", busy, frame_start, h_cnt, v_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      while (!(e_h == 11'd6 && e_v == 11'd2) && k < int'(3 * FT)) begin tick(); k++; end
      rst = 1'b0; tick(); rst = 1'b1;
      checks++;
      if (w_obs !== 46'd0) begin
         errors++; $display("FAIL reset_mid: got %h want %h", w_obs, 46'd0);
      end
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || w_obs !== w_exp) begin
            errors++; $display("FAIL reset_mid_idle cyc %0d: got %h want %h", c, w_obs, w_exp);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         checks++;
         if (w_obs !== w_exp) begin
            errors++; $display("FAIL random cyc %0d: got %h want %h", c, w_obs, w_exp);
         end
         rst   = ($urandom % 400) != 0;
         start = ($urandom % 25) == 0;
         stop  = ($urandom % 20) == 0;
         tick();
      end
      rst = 1'b1; start = 1'b0; stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame();
      test_stop();
      test_drain_restart();
      test_start_at_last();
      test_idle_start_stop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time %0t reached before completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
